gpio_bank_wb8: RTL and testbench

Parametrised GPIO bank on the 8-bit Wishbone peripheral bus of the SPU32 SoC. It is the successor to the fixed 8-bit LED output port and provides:
- WIDTH bidirectional pins with per-bit direction.
- Synchronised inputs.
- Atomic toggle writes.
- Per-bit edge-detect interrupts, collected on a single level-high O_irq line for the CPU interrupt input.

---
 rtl/gpio_bank_wb8.sv | 111 +++++++++++
 tb/tb_gpio_bank_wb8.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_wb8.sv
// WIDTH-pin GPIO bank on the 8-bit Wishbone bus: direction, toggle writes, edge interrupts.
// Ack one cycle after stb (no wait states); a pin edge reaches ISTAT/O_irq two edges after sampling.
module gpio_bank_wb8 #(
  parameter int WIDTH = 16
) (
  input  logic             I_wb_clk,
  input  logic             I_reset,
  input  logic [4:0]       I_wb_adr,
  input  logic [7:0]       I_wb_dat,
  input  logic             I_wb_stb,
  input  logic             I_wb_we,
  output logic             O_wb_ack,
  output logic [7:0]       O_wb_dat,
  input  logic [WIDTH-1:0] I_gpio_in,
  output logic [WIDTH-1:0] O_gpio_out,
  output logic [WIDTH-1:0] O_gpio_oe,
  output logic             O_irq
);

  typedef enum logic [2:0] {
    R_OUT, R_DIR, R_IN, R_IEN, R_ISTAT, R_EDGE, R_BOTH, R_TOGGLE
  } reg_e;

  logic [WIDTH-1:0] out_q, dir_q, ien_q, istat_q, edge_q, both_q;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]       arm_q;

  reg_e             sel;
  logic [4:0]       lane_shift;
  logic             commit, wr;
  logic [WIDTH-1:0] lane_mask, wr_bits, clr_bits, rd_word;
  logic [WIDTH-1:0] rise, fall, hit;
  logic [7:0]       rd_byte;

  assign sel        = reg_e'(I_wb_adr[4:2]);
  assign lane_shift = {I_wb_adr[1:0], 3'b000};
  assign commit     = I_wb_stb & ~O_wb_ack;
  assign wr         = commit & I_wb_we;

  // Bits above WIDTH fall off the truncation, so lanes past the last byte are inert.
  assign lane_mask = WIDTH'(32'h0000_00ff << lane_shift);
  assign wr_bits   = WIDTH'({24'h0, I_wb_dat} << lane_shift);
  assign clr_bits  = (wr && sel == R_ISTAT) ? wr_bits : '0;

  always_comb begin
    rd_word = '0;
    case (sel)
      R_OUT:   rd_word = out_q;
      R_DIR:   rd_word = dir_q;
      R_IN:    rd_word = sync2_q;
      R_IEN:   rd_word = ien_q;
      R_ISTAT: rd_word = istat_q;
      R_EDGE:  rd_word = edge_q;
      R_BOTH:  rd_word = both_q;
      default: rd_word = '0;
    endcase
  end

  assign rd_byte = 8'(32'(rd_word) >> lane_shift);

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;
  // Held off until the sync/prev pipeline has been refilled with real pin values.
  assign hit  = (arm_q == 2'd3)
              ? ((both_q & (rise | fall)) | (~both_q & edge_q & fall) | (~both_q & ~edge_q & rise))
              : '0;

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      istat_q  <= '0;
      edge_q   <= '0;
      both_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      arm_q    <= 2'd0;
      O_wb_ack <= 1'b0;
      O_wb_dat <= 8'h00;
    end else begin
      sync1_q  <= I_gpio_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;

      O_wb_ack <= commit;
      if (commit) O_wb_dat <= rd_byte;

      istat_q  <= (istat_q & ~clr_bits) | hit;

      if (wr) begin
        case (sel)
          R_OUT:    out_q  <= (out_q  & ~lane_mask) | wr_bits;
          R_DIR:    dir_q  <= (dir_q  & ~lane_mask) | wr_bits;
          R_IEN:    ien_q  <= (ien_q  & ~lane_mask) | wr_bits;
          R_EDGE:   edge_q <= (edge_q & ~lane_mask) | wr_bits;
          R_BOTH:   both_q <= (both_q & ~lane_mask) | wr_bits;
          R_TOGGLE: out_q  <= out_q ^ wr_bits;
          default:  ;
        endcase
      end
    end
  end

  assign O_gpio_out = out_q;
  assign O_gpio_oe  = dir_q;
  assign O_irq      = |(istat_q & ien_q);

endmodule

// File: tb/tb_gpio_bank_wb8.sv
// Bench for gpio_bank_wb8: history-based reference model checked every cycle, plus directed literals.
module tb_gpio_bank_wb8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   adr = '0;
  logic [7:0]   dat = '0;
  logic         stb = 1'b0, stb12 = 1'b0, we = 1'b0;
  logic         ack, ack12, irq, irq12;
  logic [7:0]   rdat, rdat12;
  logic [W-1:0] pins = '0;
  logic [W-1:0] gout, goe;
  logic [11:0]  gout12, goe12;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bank_wb8 #(.WIDTH(16)) dut (
    .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_dat(dat),
    .I_wb_stb(stb), .I_wb_we(we), .O_wb_ack(ack), .O_wb_dat(rdat),
    .I_gpio_in(pins), .O_gpio_out(gout), .O_gpio_oe(goe), .O_irq(irq)
  );

  gpio_bank_wb8 #(.WIDTH(12)) u12 (
    .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_dat(dat),
    .I_wb_stb(stb12), .I_wb_we(we), .O_wb_ack(ack12), .O_wb_dat(rdat12),
    .I_gpio_in(12'h000), .O_gpio_out(gout12), .O_gpio_oe(goe12), .O_irq(irq12)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: registers as plain values, pins as a history of sampled words.
  logic [W-1:0] m_out, m_dir, m_ien, m_istat, m_edge, m_both;
  logic         m_ack;
  logic [7:0]   m_dat;
  logic [W-1:0] hist[$];
  int           ecnt;
  bit           started = 0;

  function automatic logic [7:0] mread(int sel, int lane, logic [W-1:0] inv);
    logic [31:0] v;
    case (sel)
      0: v = 32'(m_out);
      1: v = 32'(m_dir);
      2: v = 32'(inv);
      3: v = 32'(m_ien);
      4: v = 32'(m_istat);
      5: v = 32'(m_edge);
      6: v = 32'(m_both);
      default: v = 32'h0;
    endcase
    return 8'(v >> (8 * lane));
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] inv, hit, rise, fall, mask, wbits, nxt;
    int sel, lane;
    bit commit;
    if (rst) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_istat = '0; m_edge = '0; m_both = '0;
      m_ack = 1'b0; m_dat = 8'h00;
      hist.delete();
      ecnt = 0;
      started = 1;
    end else begin
      ecnt++;
      sel  = int'(adr[4:2]);
      lane = int'(adr[1:0]);
      // IN before edge e shows the pin sampled at edge e-2.
      inv  = (hist.size() >= 2) ? hist[1] : '0;
      hit  = '0;
      if (ecnt >= 4) begin
        rise = hist[1] & ~hist[2];
        fall = ~hist[1] & hist[2];
        for (int i = 0; i < W; i++)
          hit[i] = m_both[i] ? (rise[i] | fall[i]) : (m_edge[i] ? fall[i] : rise[i]);
      end
      mask   = W'(32'hFF << (8 * lane));
      wbits  = W'(32'(dat) << (8 * lane));
      nxt    = m_istat | hit;
      commit = stb && !m_ack;
      if (commit) begin
        m_dat = mread(sel, lane, inv);
        if (we) begin
          case (sel)
            0: m_out  = (m_out  & ~mask) | wbits;
            1: m_dir  = (m_dir  & ~mask) | wbits;
            3: m_ien  = (m_ien  & ~mask) | wbits;
            4: nxt    = (m_istat & ~wbits) | hit;
            5: m_edge = (m_edge & ~mask) | wbits;
            6: m_both = (m_both & ~mask) | wbits;
            7: m_out  = m_out ^ wbits;
            default: ;
          endcase
        end
      end
      m_istat = nxt;
      m_ack   = commit;
      hist.push_front(pins);
      if (hist.size() > 4) void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("gpio_out", 32'(gout), 32'(m_out));
      chk("gpio_oe",  32'(goe),  32'(m_dir));
      chk("irq",      32'(irq),  32'(|(m_istat & m_ien)));
      chk("wb_ack",   32'(ack),  32'(m_ack));
      chk("wb_dat",   32'(rdat), 32'(m_dat));
    end
  end

  task automatic bus(input bit u, input bit w, input logic [4:0] a, input logic [7:0] d,
                     output logic [7:0] r);
    int n = 0;
    @(negedge clk);
    we = w; adr = a; dat = d;
    if (u) stb12 = 1'b1; else stb = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(u ? ack12 : ack) && n < 20);
    chk("ack_latency", 32'(n), 32'd1);
    r = u ? rdat12 : rdat;
    stb = 1'b0; stb12 = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 8; s++)
      for (int l = 0; l < 2; l++) begin
        bus(1'b0, 1'b0, 5'(s * 4 + l), 8'h00, r);
        chk("reset_read", 32'(r), 32'h0);
      end
    chk("reset_oe", 32'(goe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    bus(1'b0, 1'b1, {3'd0, 2'd0}, 8'hA5, r);
    bus(1'b0, 1'b1, {3'd0, 2'd1}, 8'h3C, r);
    chk("out_write", 32'(gout), 32'h3CA5);
    bus(1'b0, 1'b1, {3'd7, 2'd0}, 8'h0F, r);
    chk("toggle", 32'(gout), 32'h3CAA);
    bus(1'b0, 1'b0, {3'd7, 2'd0}, 8'h00, r);
    chk("toggle_read", 32'(r), 32'h0);

    // Rising edge on pin 0: sampled at edge N, irq visible after edge N+2.
    bus(1'b0, 1'b1, {3'd3, 2'd0}, 8'h01, r);
    @(negedge clk); pins[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("irq_n_plus_1", 32'(irq), 32'h0);
    @(negedge clk); chk("irq_n_plus_2", 32'(irq), 32'h1);
    bus(1'b0, 1'b0, {3'd4, 2'd0}, 8'h00, r);
    chk("istat_rise", 32'(r), 32'h01);
    bus(1'b0, 1'b1, {3'd4, 2'd0}, 8'h01, r);
    chk("irq_cleared", 32'(irq), 32'h0);

    bus(1'b0, 1'b1, {3'd3, 2'd0}, 8'h00, r);
    bus(1'b0, 1'b1, {3'd5, 2'd0}, 8'h02, r);
    bus(1'b0, 1'b1, {3'd6, 2'd0}, 8'h04, r);
    @(negedge clk); pins[2:1] = 2'b11;
    repeat (4) @(negedge clk);
    pins[2:1] = 2'b00;
    repeat (4) @(negedge clk);
    bus(1'b0, 1'b0, {3'd4, 2'd0}, 8'h00, r);
    chk("edge_modes", 32'(r), 32'h06);
    chk("irq_masked", 32'(irq), 32'h0);
    bus(1'b0, 1'b1, {3'd4, 2'd0}, 8'h06, r);

    // W1C commit edge coincides with the hit edge for pin 0.
    @(negedge clk); pins[0] = 1'b0;
    repeat (4) @(negedge clk);
    pins[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    adr = {3'd4, 2'd0}; dat = 8'h01; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("set_wins_ack", 32'(ack), 32'h1);
    stb = 1'b0; we = 1'b0;
    bus(1'b0, 1'b0, {3'd4, 2'd0}, 8'h00, r);
    chk("set_wins", 32'(r), 32'h01);

    @(negedge clk);
    adr = {3'd2, 2'd0}; we = 1'b0; stb = 1'b1; rst = 1'b1; pins = '1;
    @(negedge clk);
    chk("reset_abort_ack", 32'(ack), 32'h0);
    stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    bus(1'b0, 1'b0, {3'd4, 2'd0}, 8'h00, r);
    chk("arm_istat_l0", 32'(r), 32'h0);
    bus(1'b0, 1'b0, {3'd4, 2'd1}, 8'h00, r);
    chk("arm_istat_l1", 32'(r), 32'h0);
    bus(1'b0, 1'b0, {3'd2, 2'd1}, 8'h00, r);
    chk("in_high", 32'(r), 32'hFF);

    bus(1'b1, 1'b1, {3'd0, 2'd1}, 8'hFF, r);
    bus(1'b1, 1'b1, {3'd0, 2'd2}, 8'hFF, r);
    bus(1'b1, 1'b0, {3'd0, 2'd1}, 8'h00, r);
    chk("w12_lane1", 32'(r), 32'h0F);
    bus(1'b1, 1'b0, {3'd0, 2'd2}, 8'h00, r);
    chk("w12_lane2", 32'(r), 32'h00);
    bus(1'b1, 1'b0, {3'd0, 2'd3}, 8'h00, r);
    chk("w12_lane3", 32'(r), 32'h00);
    chk("w12_out", 32'(gout12), 32'hF00);

    for (int k = 0; k < 600; k++) begin
      int sel, lane;
      sel  = $urandom_range(0, 7);
      lane = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) pins ^= W'(1 << $urandom_range(0, W - 1));
      bus(1'b0, 1'($urandom_range(0, 1)), 5'(sel * 4 + lane), 8'($urandom), r);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) pins ^= W'(1 << $urandom_range(0, W - 1));
      end
      if (k % 200 == 199) begin
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
